// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter: operation codes and FSM encoding.
package shifter_pkg;

    localparam logic [2:0] MODE_PASS = 3'b000;
    localparam logic [2:0] MODE_LSL  = 3'b001;
    localparam logic [2:0] MODE_LSR  = 3'b010;
    localparam logic [2:0] MODE_ASR  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Codes 110 and 111 carry no operation; they complete at once and flag err.
    function automatic logic is_reserved(input logic [2:0] m);
        return (m == 3'b110) || (m == 3'b111);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of k positions (k = 0..STEP).
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH),
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       mode,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    // k is widened to a common width that can also hold WIDTH itself.
    localparam int KXW = AMT_W + 1;
    typedef logic [KXW-1:0] kx_t;
    localparam kx_t W_X   = kx_t'(WIDTH);
    localparam kx_t ONE_X = kx_t'(1);

    kx_t              kk;
    logic [WIDTH-1:0] lsl_out_s;
    logic [WIDTH-1:0] lsr_out_s;

    assign kk = kx_t'(k);
    // Bit WIDTH-k lands at position 0 after this shift; it is the last bit an LSL pushes out.
    assign lsl_out_s = value >> (W_X - kk);
    // Bit k-1 lands at position 0; it is the last bit a right shift pushes out.
    assign lsr_out_s = value >> (kk - ONE_X);

    // Select the operation; zero movement always reports carry 0.
    always_comb begin
        result = value;
        carry  = 1'b0;
        case (mode)
            MODE_LSL: begin
                result = value << kk;
                carry  = lsl_out_s[0];
            end
            MODE_LSR: begin
                result = value >> kk;
                carry  = lsr_out_s[0];
            end
            MODE_ASR: begin
                result = WIDTH'($signed(value) >>> kk);
                carry  = lsr_out_s[0];
            end
            MODE_ROR: begin
                result = (value >> kk) | (value << (W_X - kk));
                carry  = result[WIDTH-1];
            end
            MODE_ROL: begin
                result = (value << kk) | (value >> (W_X - kk));
                carry  = result[0];
            end
            default: begin
                result = value;
                carry  = 1'b0;
            end
        endcase
        if (kk == kx_t'(0)) begin
            carry = 1'b0;
        end else begin
            carry = carry;
        end
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter/rotator: moves up to STEP positions per clock with a start/busy/done handshake.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sout,
    output logic             carry,
    output logic             err
);

    localparam int KW  = $clog2(STEP + 1);
    localparam int KXW = AMT_W + 1;
    typedef logic [KXW-1:0] kx_t;
    localparam kx_t STEP_X = kx_t'(STEP);

    state_t           state_r, state_next_s;
    logic [AMT_W-1:0] rem_r;
    logic [WIDTH-1:0] work_r;
    logic             carry_r;
    logic [2:0]       mode_r;
    logic             err_r;

    logic             accept_s;
    logic             short_s;
    kx_t              rem_x_s;
    kx_t              k_x_s;
    logic [WIDTH-1:0] step_val_s;
    logic             step_carry_s;

    assign accept_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));
    // Operations with nothing to move skip RUN entirely.
    assign short_s  = (amt == '0) || (mode == MODE_PASS) || is_reserved(mode);
    assign rem_x_s  = kx_t'(rem_r);
    assign k_x_s    = (rem_x_s < STEP_X) ? rem_x_s : STEP_X;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .AMT_W (AMT_W),
        .KW    (KW)
    ) u_step (
        .value  (work_r),
        .mode   (mode_r),
        .k      (k_x_s[KW-1:0]),
        .result (step_val_s),
        .carry  (step_carry_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; DONE accepts a new start just like IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = short_s ? S_DONE : S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (rem_x_s <= STEP_X) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_next_s = short_s ? S_DONE : S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Working register, remaining count, carry and latched operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_r  <= '0;
            rem_r   <= '0;
            carry_r <= 1'b0;
            mode_r  <= MODE_PASS;
            err_r   <= 1'b0;
        end else if (accept_s) begin
            work_r  <= in;
            rem_r   <= amt;
            carry_r <= 1'b0;
            mode_r  <= mode;
            err_r   <= is_reserved(mode);
        end else if (state_r == S_RUN) begin
            work_r  <= step_val_s;
            rem_r   <= rem_r - k_x_s[AMT_W-1:0];
            carry_r <= step_carry_s;
        end
    end

    assign busy  = (state_r == S_RUN);
    assign done  = (state_r == S_DONE);
    assign err   = (state_r == S_DONE) && err_r;
    assign sout  = work_r;
    assign carry = carry_r;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter with STEP=1 and STEP=4 instances side by side.
module tb_iter_shifter;
    import shifter_pkg::*;

    logic        clk;
    logic        reset;
    logic        start1, start4;
    logic [15:0] in_v;
    logic [2:0]  mode_v;
    logic [3:0]  amt_v;
    logic        busy1, done1, carry1, err1;
    logic        busy4, done4, carry4, err4;
    logic [15:0] sout1, sout4;

    int n_checks;
    int n_errors;

    iter_shifter #(.WIDTH(16), .STEP(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .in(in_v), .mode(mode_v), .amt(amt_v),
        .busy(busy1), .done(done1), .sout(sout1), .carry(carry1), .err(err1)
    );

    iter_shifter #(.WIDTH(16), .STEP(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .in(in_v), .mode(mode_v), .amt(amt_v),
        .busy(busy4), .done(done4), .sout(sout4), .carry(carry4), .err(err4)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at 1 time unit after a rising edge; presents a request for one edge.
    task automatic launch(input int sel, input logic [15:0] i, input logic [2:0] m, input logic [3:0] a);
        in_v = i; mode_v = m; amt_v = a;
        if (sel == 4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
    endtask

    // Counts RUN cycles until done, bounded; leaves time in the DONE cycle.
    task automatic wait_done(input int sel, output int cycles, output bit ok);
        logic b, d;
        cycles = 0; ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            b = (sel == 4) ? busy4 : busy1;
            d = (sel == 4) ? done4 : done1;
            if (d) begin
                ok = 1'b1;
                break;
            end
            if (b) cycles++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input string tag, input int sel, input logic [15:0] i, input logic [2:0] m,
                          input logic [3:0] a, input logic [15:0] exp_s, input logic exp_c,
                          input logic exp_e, input int exp_n);
        int  cyc;
        bit  ok;
        launch(sel, i, m, a);
        wait_done(sel, cyc, ok);
        check_val({tag, "_done"}, 32'(ok), 32'd1);
        check_val({tag, "_cycles"}, 32'(cyc), 32'(exp_n));
        check_val({tag, "_sout"}, 32'((sel == 4) ? sout4 : sout1), 32'(exp_s));
        check_val({tag, "_carry"}, 32'((sel == 4) ? carry4 : carry1), 32'(exp_c));
        check_val({tag, "_err"}, 32'((sel == 4) ? err4 : err1), 32'(exp_e));
        @(posedge clk); #1;
        check_val({tag, "_done_pulse"}, 32'((sel == 4) ? done4 : done1), 32'd0);
        check_val({tag, "_err_after"}, 32'((sel == 4) ? err4 : err1), 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  ok;
        bit  seen;
        n_checks = 0; n_errors = 0;
        reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
        in_v = 16'h0000; mode_v = 3'b000; amt_v = 4'd0;
        #2;
        check_val("rst_busy", 32'({busy1, busy4}), 32'd0);
        check_val("rst_done", 32'({done1, done4}), 32'd0);
        check_val("rst_sout", 32'({sout1, sout4}), 32'd0);
        check_val("rst_carry_err", 32'({carry1, carry4, err1, err4}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("t1_lsl", 1, 16'h8001, MODE_LSL, 4'd1, 16'h0002, 1'b1, 1'b0, 1);
        run_op("t2_asr1", 1, 16'h8F00, MODE_ASR, 4'd4, 16'hF8F0, 1'b0, 1'b0, 4);
        run_op("t2_asr4", 4, 16'h8F00, MODE_ASR, 4'd4, 16'hF8F0, 1'b0, 1'b0, 1);
        run_op("t3_lsr1", 1, 16'hFFFF, MODE_LSR, 4'd15, 16'h0001, 1'b1, 1'b0, 15);
        run_op("t3_lsr4", 4, 16'hFFFF, MODE_LSR, 4'd15, 16'h0001, 1'b1, 1'b0, 4);
        run_op("lsl7_s4", 4, 16'h1234, MODE_LSL, 4'd7, 16'h1A00, 1'b1, 1'b0, 2);
        run_op("rol8_s4", 4, 16'h1234, MODE_ROL, 4'd8, 16'h3412, 1'b0, 1'b0, 2);
        run_op("ror5_s4", 4, 16'h0010, MODE_ROR, 4'd5, 16'h8000, 1'b1, 1'b0, 2);

        // Back-to-back: ROR finishes, ROL is requested in the DONE cycle.
        launch(1, 16'h1234, MODE_ROR, 4'd4);
        wait_done(1, cyc, ok);
        check_val("t4_ror_done", 32'(ok), 32'd1);
        check_val("t4_ror_cycles", 32'(cyc), 32'd4);
        check_val("t4_ror_sout", 32'(sout1), 32'h4123);
        check_val("t4_ror_carry", 32'(carry1), 32'd0);
        launch(1, 16'h1234, MODE_ROL, 4'd8);
        check_val("t4_b2b_busy", 32'(busy1), 32'd1);
        // A start during RUN must be ignored.
        in_v = 16'hFFFF; mode_v = MODE_LSL; amt_v = 4'd3; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_done(1, cyc, ok);
        check_val("t4_rol_done", 32'(ok), 32'd1);
        check_val("t4_rol_cycles", 32'(cyc + 1), 32'd8);
        check_val("t4_rol_sout", 32'(sout1), 32'h3412);
        check_val("t4_rol_carry", 32'(carry1), 32'd0);
        @(posedge clk); #1;
        check_val("t4_no_queue", 32'({busy1, done1}), 32'd0);

        run_op("t5_amt0", 1, 16'hABCD, MODE_LSL, 4'd0, 16'hABCD, 1'b0, 1'b0, 0);
        run_op("t5_rsv", 1, 16'hABCD, 3'b110, 4'd5, 16'hABCD, 1'b0, 1'b1, 0);
        run_op("t5_rsv4", 4, 16'hABCD, 3'b111, 4'd3, 16'hABCD, 1'b0, 1'b1, 0);
        run_op("t5_pass", 4, 16'h5A5A, MODE_PASS, 4'd9, 16'h5A5A, 1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of a RUN.
        launch(1, 16'hFFFF, MODE_LSR, 4'd10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("t6_pre_busy", 32'(busy1), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_val("t6_busy", 32'(busy1), 32'd0);
        check_val("t6_done", 32'(done1), 32'd0);
        check_val("t6_sout", 32'(sout1), 32'd0);
        check_val("t6_carry", 32'(carry1), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (done1 || busy1) seen = 1'b1;
        end
        check_val("t6_quiet", 32'(seen), 32'd0);
        run_op("t6_after", 1, 16'h00F0, MODE_LSR, 4'd4, 16'h000F, 1'b0, 1'b0, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
